// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Detects RAW and load-use hazards and sequences branch flushes. A data-memory
// req/ack FSM (RUN / MEM_WAIT / ERR) freezes the pipeline during an outstanding
// MEM access and latches a sticky timeout error. A saturating counter tracks
// the cycles in which the PC is not written.
// Optional build macro PIPE_HAZARD_FWD_EN: enables the EX operand forwarding
// selects and limits stalls to load-use hazards.
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memrd,
  input  logic             mem_memwr,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  input  logic             pcsrc,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic             dmem_req,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam logic [7:0]       TIMEOUT  = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             load_use;
  logic             raw_hazard;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             hold;
  logic             req;
  logic             branch;
  logic             stall;
  logic             pc_we;

  // A source/destination pair only counts when the writer is live and not r0.
  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic             use_src,
                                   input logic [REG_W-1:0] dst,
                                   input logic             dst_wr);
    reg_hit = use_src & dst_wr & (dst != REG_ZERO) & (src == dst);
  endfunction

`ifndef PIPE_HAZARD_FWD_EN
  // Forwarding-only inputs have no consumer in the stall-only build.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
`endif

  // Hazard decode and forwarding selects from the stage register fields.
  always_comb begin
    load_use = reg_hit(id_rs, id_use_rs, ex_rd, ex_memread) |
               reg_hit(id_rt, id_use_rt, ex_rd, ex_memread);
`ifdef PIPE_HAZARD_FWD_EN
    raw_hazard = load_use;
    if (reg_hit(ex_rs, 1'b1, mem_rd, mem_regwrite)) begin
      fwd_a_sel = 2'b10;
    end else if (reg_hit(ex_rs, 1'b1, wb_rd, wb_regwrite)) begin
      fwd_a_sel = 2'b01;
    end else begin
      fwd_a_sel = 2'b00;
    end
    if (reg_hit(ex_rt, 1'b1, mem_rd, mem_regwrite)) begin
      fwd_b_sel = 2'b10;
    end else if (reg_hit(ex_rt, 1'b1, wb_rd, wb_regwrite)) begin
      fwd_b_sel = 2'b01;
    end else begin
      fwd_b_sel = 2'b00;
    end
`else
    // Without forwarding, any in-flight writer in EX or MEM blocks ID.
    raw_hazard = load_use |
                 reg_hit(id_rs, id_use_rs, ex_rd, ex_regwrite) |
                 reg_hit(id_rt, id_use_rt, ex_rd, ex_regwrite) |
                 reg_hit(id_rs, id_use_rs, mem_rd, mem_regwrite) |
                 reg_hit(id_rt, id_use_rt, mem_rd, mem_regwrite);
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
`endif
  end

  // Data-memory handshake FSM: next state, wait counter, hold and request.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hold       = 1'b0;
    req        = 1'b0;
    case (state_q)
      ST_RUN: begin
        req        = mem_memrd | mem_memwr;
        wait_cnt_d = 8'd0;
        if (req && !dmem_ack) begin
          hold    = 1'b1;
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          hold       = 1'b0;
          wait_cnt_d = 8'd0;
          state_d    = ST_RUN;
        end else begin
          hold       = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == TIMEOUT) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end
      end
      ST_ERR: begin
        hold    = 1'b1;
        req     = 1'b0;
        state_d = ST_ERR;
      end
      default: begin
        // Unreachable encoding: freeze this cycle and recover to RUN.
        hold       = 1'b1;
        req        = 1'b0;
        wait_cnt_d = 8'd0;
        state_d    = ST_RUN;
      end
    endcase
  end

  // Pipeline control arbitration (hold > branch flush > RAW stall) and counters.
  always_comb begin
    branch = pcsrc & ~hold;
    stall  = raw_hazard & ~hold & ~branch;
    pc_we  = ~hold & ~stall;
    if (!pc_we && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    mem_err_d = mem_err_q | (state_d == ST_ERR);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output drive: reset presents a free-running pipeline with everything else idle.
  always_comb begin
    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      pipe_hold   = 1'b0;
      dmem_req    = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
      mem_err     = 1'b0;
      stall_cnt   = {CNT_W{1'b0}};
    end else begin
      pc_write    = pc_we;
      ifid_write  = pc_we;
      ifid_flush  = branch;
      idex_bubble = branch | stall;
      exmem_flush = branch;
      pipe_hold   = hold;
      dmem_req    = req;
      fwd_a       = fwd_a_sel;
      fwd_b       = fwd_b_sel;
      mem_err     = mem_err_q;
      stall_cnt   = stall_cnt_q;
    end
  end

endmodule
